// File: rtl/trace_checker_pkg.sv
// Shared types and constants for the streaming trace-line checker:
// parser states, format codes, error bit positions and ASCII characters.
package trace_checker_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_TIME     = 4'd1,
    ST_PC       = 4'd2,
    ST_DEST_SEL = 4'd3,
    ST_GRF      = 4'd4,
    ST_ADDR     = 4'd5,
    ST_PRE_LT   = 4'd6,
    ST_EQ       = 4'd7,
    ST_PRE_DATA = 4'd8,
    ST_DATA     = 4'd9,
    ST_DONE     = 4'd10,
    ST_ERROR    = 4'd11
  } state_e;

  localparam logic [1:0] FMT_NONE = 2'b00;
  localparam logic [1:0] FMT_GRF  = 2'b01;
  localparam logic [1:0] FMT_ADDR = 2'b10;

  localparam int ERR_PC   = 0;
  localparam int ERR_ADDR = 1;
  localparam int ERR_GRF  = 2;
  localparam int ERR_TIME = 3;

  localparam logic [7:0] CH_CARET  = 8'h5e;
  localparam logic [7:0] CH_AT     = 8'h40;
  localparam logic [7:0] CH_COLON  = 8'h3a;
  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_STAR   = 8'h2a;
  localparam logic [7:0] CH_LT     = 8'h3c;
  localparam logic [7:0] CH_EQ     = 8'h3d;
  localparam logic [7:0] CH_HASH   = 8'h23;
  localparam logic [7:0] CH_0      = 8'h30;
  localparam logic [7:0] CH_9      = 8'h39;
  localparam logic [7:0] CH_LC_A   = 8'h61;
  localparam logic [7:0] CH_LC_F   = 8'h66;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/trace_char_class.sv
// Combinational classifier: decimal digit, lowercase hex digit, and the
// 4-bit value of the character when it is a hex digit.
module trace_char_class
  import trace_checker_pkg::*;
(
  input  logic [7:0] ch,
  output logic       is_dec,
  output logic       is_hex,
  output logic [3:0] nibble
);

  logic is_af;

  // Digit classification and value extraction.
  always_comb begin
    is_dec = (ch >= CH_0) && (ch <= CH_9);
    is_af  = (ch >= CH_LC_A) && (ch <= CH_LC_F);
    is_hex = is_dec || is_af;
    // '0'..'9' carry their value in the low nibble; 'a'..'f' sit at 1..6
    if (is_dec) begin
      nibble = ch[3:0];
    end else if (is_af) begin
      nibble = ch[3:0] + 4'd9;
    end else begin
      nibble = 4'd0;
    end
  end

endmodule

// File: rtl/trace_line_checker.sv
// Byte-serial CPU trace-line parser reporting format and decoded fields for
// one cycle per valid line. Define TRACE_CHECKER_SEMANTIC_EN for error_code.
module trace_line_checker
  import trace_checker_pkg::*;
#(
  parameter int TIME_MAX_DIGITS = 4,
  parameter int GRF_MAX_DIGITS  = 4,
  parameter int PC_DIGITS       = 8,
  parameter int ADDR_DIGITS     = 8,
  parameter int DATA_DIGITS     = 8,
  parameter logic [4*PC_DIGITS-1:0]   PC_LO   = 32'h0000_3000,
  parameter logic [4*PC_DIGITS-1:0]   PC_HI   = 32'h0000_6ffc,
  parameter logic [4*ADDR_DIGITS-1:0] ADDR_LO = 32'h0000_0000,
  parameter logic [4*ADDR_DIGITS-1:0] ADDR_HI = 32'h0000_2ffc
) (
  input  logic clk,
  input  logic reset,
  input  logic [7:0] char,
  output logic [1:0] format_type,
  output logic [$clog2(10**TIME_MAX_DIGITS)-1:0] time_val,
  output logic [4*PC_DIGITS-1:0] pc_val,
  output logic [max_int(4*ADDR_DIGITS, $clog2(10**GRF_MAX_DIGITS))-1:0] dest_val,
  output logic [4*DATA_DIGITS-1:0] data_val,
  output logic [3:0] error_code
);

  localparam int TIME_W = $clog2(10**TIME_MAX_DIGITS);
  localparam int GRF_W  = $clog2(10**GRF_MAX_DIGITS);
  localparam int PC_W   = 4*PC_DIGITS;
  localparam int ADDR_W = 4*ADDR_DIGITS;
  localparam int DATA_W = 4*DATA_DIGITS;
  localparam int DEST_W = max_int(ADDR_W, GRF_W);
  localparam int CNT_W  = $clog2(max_int(max_int(TIME_MAX_DIGITS, GRF_MAX_DIGITS),
                                 max_int(PC_DIGITS, max_int(ADDR_DIGITS, DATA_DIGITS))) + 1);

  logic is_dec, is_hex;
  logic [3:0] nibble;

  trace_char_class u_char_class (
    .ch     (char),
    .is_dec (is_dec),
    .is_hex (is_hex),
    .nibble (nibble)
  );

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        fmt_q, fmt_d;
  logic [TIME_W-1:0] time_q, time_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DEST_W-1:0] dest_q, dest_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              is_sep;

  // Next-state, digit counting and field accumulation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fmt_d   = fmt_q;
    time_d  = time_q;
    pc_d    = pc_q;
    dest_d  = dest_q;
    data_d  = data_q;
    cnt_inc = cnt_q + CNT_W'(1);
    is_sep  = (char == CH_SPACE) || (char == CH_LT);
    if (char == CH_CARET) begin
      state_d = ST_TIME;
      cnt_d   = '0;
      fmt_d   = FMT_NONE;
      time_d  = '0;
      pc_d    = '0;
      dest_d  = '0;
      data_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_TIME: begin
          if (is_dec && cnt_q != CNT_W'(TIME_MAX_DIGITS)) begin
            time_d = TIME_W'(time_q * TIME_W'(10) + TIME_W'(nibble));
            cnt_d  = cnt_inc;
          end else if (char == CH_AT && cnt_q != '0) begin
            state_d = ST_PC;
            cnt_d   = '0;
          end else begin
            state_d = ST_ERROR;
          end
        end
        ST_PC: begin
          if (is_hex && cnt_q != CNT_W'(PC_DIGITS)) begin
            pc_d  = (pc_q << 4) | PC_W'(nibble);
            cnt_d = cnt_inc;
          end else if (char == CH_COLON && cnt_q == CNT_W'(PC_DIGITS)) begin
            state_d = ST_DEST_SEL;
            cnt_d   = '0;
          end else begin
            state_d = ST_ERROR;
          end
        end
        ST_DEST_SEL: begin
          if (char == CH_SPACE) begin
            state_d = ST_DEST_SEL;
          end else if (char == CH_DOLLAR) begin
            state_d = ST_GRF;
            fmt_d   = FMT_GRF;
          end else if (char == CH_STAR) begin
            state_d = ST_ADDR;
            fmt_d   = FMT_ADDR;
          end else begin
            state_d = ST_ERROR;
          end
        end
        ST_GRF: begin
          if (is_dec && cnt_q != CNT_W'(GRF_MAX_DIGITS)) begin
            dest_d = DEST_W'(dest_q * DEST_W'(10) + DEST_W'(nibble));
            cnt_d  = cnt_inc;
          end else if (is_sep && cnt_q != '0) begin
            state_d = (char == CH_LT) ? ST_EQ : ST_PRE_LT;
            cnt_d   = '0;
          end else begin
            state_d = ST_ERROR;
          end
        end
        ST_ADDR: begin
          if (is_hex && cnt_q != CNT_W'(ADDR_DIGITS)) begin
            dest_d = (dest_q << 4) | DEST_W'(nibble);
            cnt_d  = cnt_inc;
          end else if (is_sep && cnt_q == CNT_W'(ADDR_DIGITS)) begin
            state_d = (char == CH_LT) ? ST_EQ : ST_PRE_LT;
            cnt_d   = '0;
          end else begin
            state_d = ST_ERROR;
          end
        end
        ST_PRE_LT: begin
          if (char == CH_SPACE) begin
            state_d = ST_PRE_LT;
          end else if (char == CH_LT) begin
            state_d = ST_EQ;
          end else begin
            state_d = ST_ERROR;
          end
        end
        ST_EQ: state_d = (char == CH_EQ) ? ST_PRE_DATA : ST_ERROR;
        // The first data digit also leaves the optional-space state
        ST_PRE_DATA: begin
          if (char == CH_SPACE) begin
            state_d = ST_PRE_DATA;
          end else if (is_hex) begin
            state_d = ST_DATA;
            data_d  = DATA_W'(nibble);
            cnt_d   = CNT_W'(1);
          end else begin
            state_d = ST_ERROR;
          end
        end
        ST_DATA: begin
          if (is_hex && cnt_q != CNT_W'(DATA_DIGITS)) begin
            data_d = (data_q << 4) | DATA_W'(nibble);
            cnt_d  = cnt_inc;
          end else if (char == CH_HASH && cnt_q == CNT_W'(DATA_DIGITS)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ERROR;
          end
        end
        ST_DONE:  state_d = ST_ERROR;
        ST_ERROR: state_d = ST_ERROR;
        default:  state_d = ST_ERROR;
      endcase
    end
  end

  // Parser state and field registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      fmt_q   <= FMT_NONE;
      time_q  <= '0;
      pc_q    <= '0;
      dest_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fmt_q   <= fmt_d;
      time_q  <= time_d;
      pc_q    <= pc_d;
      dest_q  <= dest_d;
      data_q  <= data_d;
    end
  end

`ifdef TRACE_CHECKER_SEMANTIC_EN
  logic [TIME_W-1:0] prev_time_q, prev_time_d;
  logic [ADDR_W-1:0] addr_s;

  // Timestamp of the last reported line, taken whether or not it was flagged.
  always_comb begin
    prev_time_d = (state_q == ST_DONE) ? time_q : prev_time_q;
  end

  // Previous-timestamp register.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_time_q <= '0;
    end else begin
      prev_time_q <= prev_time_d;
    end
  end
`endif

  // Moore outputs: everything is zero outside the single DONE cycle.
  always_comb begin
    format_type = FMT_NONE;
    time_val    = '0;
    pc_val      = '0;
    dest_val    = '0;
    data_val    = '0;
    error_code  = 4'b0000;
`ifdef TRACE_CHECKER_SEMANTIC_EN
    addr_s      = dest_q[ADDR_W-1:0];
`endif
    if (state_q == ST_DONE) begin
      format_type = fmt_q;
      time_val    = time_q;
      pc_val      = pc_q;
      dest_val    = dest_q;
      data_val    = data_q;
`ifdef TRACE_CHECKER_SEMANTIC_EN
      error_code[ERR_PC]   = (pc_q < PC_LO) || (pc_q > PC_HI) || (pc_q[1:0] != 2'b00);
      error_code[ERR_ADDR] = (fmt_q == FMT_ADDR) &&
                             ((addr_s < ADDR_LO) || (addr_s > ADDR_HI) || (addr_s[1:0] != 2'b00));
      error_code[ERR_GRF]  = (fmt_q == FMT_GRF) && (dest_q > DEST_W'(31));
      error_code[ERR_TIME] = (time_q < prev_time_q);
`endif
    end else begin
      format_type = FMT_NONE;
    end
  end

endmodule

// File: tb/tb_trace_line_checker.sv
// Scoreboard bench for trace_line_checker: expected line reports are queued
// with their due cycle and compared when that cycle is observed.
module tb_trace_line_checker;

  logic        clk;
  logic        reset;
  logic [7:0]  char;
  logic [1:0]  format_type;
  logic [13:0] time_val;
  logic [31:0] pc_val;
  logic [31:0] dest_val;
  logic [31:0] data_val;
  logic [3:0]  error_code;

  trace_line_checker dut (
    .clk         (clk),
    .reset       (reset),
    .char        (char),
    .format_type (format_type),
    .time_val    (time_val),
    .pc_val      (pc_val),
    .dest_val    (dest_val),
    .data_val    (data_val),
    .error_code  (error_code)
  );

  typedef struct {
    int          due;
    logic [1:0]  fmt;
    logic [13:0] t;
    logic [31:0] pc;
    logic [31:0] dest;
    logic [31:0] data;
    logic [3:0]  err;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   n_vec;
  int   n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic observe();
    exp_t e;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check_val("format_type", 128'(format_type), 128'(e.fmt));
      check_val("time_val",    128'(time_val),    128'(e.t));
      check_val("pc_val",      128'(pc_val),      128'(e.pc));
      check_val("dest_val",    128'(dest_val),    128'(e.dest));
      check_val("data_val",    128'(data_val),    128'(e.data));
      check_val("error_code",  128'(error_code),  128'(e.err));
    end else begin
      check_val("idle_zero",
                128'({format_type, time_val, pc_val, dest_val, data_val, error_code}),
                128'(0));
    end
  endtask

  // Check what the previous edge produced, then present the next input.
  task automatic step(input logic [7:0] c, input logic r);
    @(negedge clk);
    cyc++;
    observe();
    char  = c;
    reset = r;
  endtask

  task automatic send_line(input string s, input bit valid, input logic [1:0] f,
                           input int t, input logic [31:0] pc, input logic [31:0] dest,
                           input logic [31:0] data, input logic [3:0] e_sem);
    exp_t e;
    for (int i = 0; i < s.len(); i++) begin
      step(s[i], 1'b0);
    end
    if (valid) begin
      e.due  = cyc + 1;
      e.fmt  = f;
      e.t    = 14'(t);
      e.pc   = pc;
      e.dest = dest;
      e.data = data;
`ifdef TRACE_CHECKER_SEMANTIC_EN
      e.err  = e_sem;
`else
      e.err  = 4'b0000;
`endif
      sb.push_back(e);
    end
  endtask

  initial begin
    cyc   = 0;
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    char  = 8'h00;
    repeat (3) @(posedge clk);
    step(8'h00, 1'b1);
    step(8'h00, 1'b0);

    send_line("^10@00003000: $5 <= 0000abcd#", 1'b1, 2'b01, 10, 32'h3000, 32'd5, 32'h0000abcd, 4'b0000);
    send_line("^7@00003004:*00000010<=12345678#", 1'b1, 2'b10, 7, 32'h3004, 32'h10, 32'h12345678, 4'b1000);
    send_line(" ", 1'b0, 2'b00, 0, 32'h0, 32'h0, 32'h0, 4'b0000);
    send_line("^12345@00003000: $1 <= 00000000#", 1'b0, 2'b00, 0, 32'h0, 32'h0, 32'h0, 4'b0000);
    send_line("^1@0300: $1 <= 00000000#", 1'b0, 2'b00, 0, 32'h0, 32'h0, 32'h0, 4'b0000);
    send_line("^8@00003000: $1 <= 00000001#", 1'b1, 2'b01, 8, 32'h3000, 32'd1, 32'h1, 4'b0000);
    send_line("^1@00003000: $1 <^2@00003000: $2 <= 00000001#", 1'b1, 2'b01, 2, 32'h3000, 32'd2, 32'h1, 4'b1000);
    send_line("^20@00003000: $3 <= 00000002#", 1'b1, 2'b01, 20, 32'h3000, 32'd3, 32'h2, 4'b0000);
    send_line("^15@00003002: $40 <= 00000003#", 1'b1, 2'b01, 15, 32'h3002, 32'd40, 32'h3, 4'b1101);
    send_line("^30@00004000:*00003000 <= ffffffff#", 1'b1, 2'b10, 30, 32'h4000, 32'h3000, 32'hffffffff, 4'b0010);
    send_line("^9999@00006ffc: $0031 <= 89abcdef#", 1'b1, 2'b01, 9999, 32'h6ffc, 32'd31, 32'h89abcdef, 4'b0000);
    send_line("^1@0000300A: $1 <= 00000000#", 1'b0, 2'b00, 0, 32'h0, 32'h0, 32'h0, 4'b0000);
    send_line("^1@00003000: $12345 <= 00000000#", 1'b0, 2'b00, 0, 32'h0, 32'h0, 32'h0, 4'b0000);

    // Reset lands on the last data digit, so the following '#' must not report
    send_line("^5@00003000: $1 <= 0000000", 1'b0, 2'b00, 0, 32'h0, 32'h0, 32'h0, 4'b0000);
    step("0", 1'b1);
    step("#", 1'b0);
    step("1", 1'b0);
    step("#", 1'b0);
    send_line("^3@00003000: *00000ffc<=00000004#", 1'b1, 2'b10, 3, 32'h3000, 32'hffc, 32'h4, 4'b0000);

    repeat (4) step(" ", 1'b0);
    check_val("scoreboard_drained", 128'(sb.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
